alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Captures decoded instruction fields from ID and translates ALU-op class plus funct into the 4-bit ALU opcode.
- Resolves operands with EX/MEM and MEM/WB forwarding, then drives the ALU's aluOp/data1/data2 inputs from registered state.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, operand and result width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers this cycle.
- flush  in  1  load a bubble this cycle.
- id_valid  in  1  ID presents a valid instruction.
- id_op_class  in  2  00 = add (lw/sw/addi), 01 = sub (beq), 10 = R-type (use funct), 11 = reserved.
- id_funct  in  6  R-type funct field.
- id_rs_data  in  DATA_W  register-file read data for rs.
- id_rt_data  in  DATA_W  register-file read data for rt.
- id_imm  in  16  immediate field.
- id_alu_src  in  1  1 = data2 comes from the sign-extended immediate.
- id_rs, id_rt, id_dest  in  REG_AW each  source and destination indices.
- mem_fwd_en  in  1  EX/MEM stage will write a register.
- mem_fwd_rd  in  REG_AW  EX/MEM destination index.
- mem_fwd_data  in  DATA_W  EX/MEM result.
- wb_fwd_en  in  1  MEM/WB stage will write a register.
- wb_fwd_rd  in  REG_AW  MEM/WB destination index.
- wb_fwd_data  in  DATA_W  MEM/WB result.
- ex_valid  out  1  stage holds a valid instruction.
- aluOp  out  4  ALU opcode.
- data1  out  DATA_W  ALU operand 1.
- data2  out  DATA_W  ALU operand 2.
- ex_store_data  out  DATA_W  forwarded rt value, for stores.
- ex_dest  out  REG_AW  registered destination index.
- ex_illegal  out  1  unsupported op class or funct.

Behaviour:
- Reset: on a rising clk with reset=1, all stage registers clear.
  - ex_valid=0, aluOp=0000, ex_dest=0, ex_illegal=0, stored rs/rt data and immediate = 0.
  - data1/data2/ex_store_data follow from cleared state: 0 unless forwarding matches. Index 0 never forwards, so they are 0 after reset.
- Update priority per rising edge: reset > flush > stall > load.
- Flush: loads a bubble with the reset values. Flush beats stall in the same cycle.
- Stall (without flush): every register holds its value. Forwarding muxes stay live, so data1/data2 may change while stalled as younger producers advance.
- Load: registers capture the following:
  - ex_valid ← id_valid.
  - aluOp ← decode(id_op_class, id_funct).
  - ex_illegal ← illegal flag AND id_valid.
  - rs/rt indices, rs/rt data and id_dest are captured.
  - The immediate is captured sign-extended to DATA_W, bit 15 replicated.
  - id_valid=0 still loads, but yields ex_valid=0.
- Latency: one cycle from ID inputs to aluOp/data outputs.
- Decode table:
  - Class 00 → 0010.
  - Class 01 → 0110.
  - Class 10 with funct:
    - 100100 → 0000 (AND).
    - 100101 → 0001 (OR).
    - 100000 → 0010 (add).
    - 100010 → 0110 (sub).
    - 101010 → 0111 (slt).
    - 100111 → 1100 (NOR).
    - Any other funct → 0000, illegal=1.
  - Class 11 → 0000, illegal=1.
- Forwarding is combinational from registered indices to the outputs:
  - fwd(x) = mem_fwd_data if mem_fwd_en && mem_fwd_rd==x && x!=0.
  - Otherwise wb_fwd_data if wb_fwd_en && wb_fwd_rd==x && x!=0.
  - Otherwise the stored register data.
  - MEM beats WB when both match.
- Output assignment:
  - data1 = fwd(rs).
  - ex_store_data = fwd(rt).
  - data2 = alu_src ? sext_imm : fwd(rt).
- Forwarding is applied regardless of ex_valid. Downstream qualifies on ex_valid.
- Arithmetic: no arithmetic in this block beyond sign extension. Widths are exact; no truncation.

Decomposition:
- Package alu_pkg:
  - ALU opcode constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100).
  - Funct constants.
  - Op-class constants.
  - Width defaults.
- Sub-module alu_control: combinational (op_class, funct) → (aluOp, illegal). It is also reusable by the multi-cycle control path.
- Forwarding mux and pipeline registers stay in alu_issue_stage.

Test Plan:
- Reset, then idle → ex_valid=0, aluOp=0000, data1=data2=0, ex_illegal=0.
- Load class 10, funct 100010, rs_data=0x00000005, rt_data=0x00000003, no forwarding → next cycle: aluOp=0110, data1=5, data2=3, ex_valid=1.
- Load class 00, alu_src=1, imm=0xFFFC, rs_data=0x100 → data2=0xFFFFFFFC, aluOp=0010.
- rs=rt=7 with mem_fwd_en=1, rd=7, data 0xAAAA0000, and wb_fwd_en=1, rd=7, data 0x5555 → data1=ex_store_data=0xAAAA0000. Repeat with rs=rt=0 and both forwarding rd=0 → stored values, not forwarded.
- stall=1 for 3 cycles while ID inputs change → outputs unchanged. Then flush=1 together with stall=1 → next cycle ex_valid=0, aluOp=0000.
- Class 10, funct 000000 → ex_illegal=1, aluOp=0000. Class 11 with id_valid=0 → ex_illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, funct codes, op classes and width defaults
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        OPC_ADD   = 2'b00,
        OPC_SUB   = 2'b01,
        OPC_RTYPE = 2'b10,
        OPC_RSVD  = 2'b11
    } op_class_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational op-class/funct to ALU opcode decoder
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] i_op_class,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = ALU_AND;
        o_illegal = 1'b0;
        case (op_class_e'(i_op_class))
            OPC_ADD: o_alu_op = ALU_ADD;
            OPC_SUB: o_alu_op = ALU_SUB;
            OPC_RTYPE: begin
                case (i_funct)
                    FUNCT_AND: o_alu_op = ALU_AND;
                    FUNCT_OR:  o_alu_op = ALU_OR;
                    FUNCT_ADD: o_alu_op = ALU_ADD;
                    FUNCT_SUB: o_alu_op = ALU_SUB;
                    FUNCT_SLT: o_alu_op = ALU_SLT;
                    FUNCT_NOR: o_alu_op = ALU_NOR;
                    default:   o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX register stage with opcode decode and EX/MEM, MEM/WB forwarding
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_op_class,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              id_alu_src,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              ex_valid,
    output logic [3:0]        aluOp,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_illegal
);

    logic [3:0]        w_alu_op;
    logic              w_illegal;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    logic              r_valid;
    logic [3:0]        r_alu_op;
    logic              r_illegal;
    logic              r_alu_src;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    alu_control u_alu_control (
        .i_op_class (id_op_class),
        .i_funct    (id_funct),
        .o_alu_op   (w_alu_op),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid   <= 1'b0;
            r_alu_op  <= ALU_AND;
            r_illegal <= 1'b0;
            r_alu_src <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_alu_op  <= w_alu_op;
            r_illegal <= w_illegal & id_valid;
            r_alu_src <= id_alu_src;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_dest    <= id_dest;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= {{(DATA_W-16){id_imm[15]}}, id_imm};
        end
    end

    // Register 0 is hardwired, so it never matches a producer; the younger MEM result wins over WB.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              m_en,
        input logic [REG_AW-1:0] m_rd,
        input logic [DATA_W-1:0] m_data,
        input logic              w_en,
        input logic [REG_AW-1:0] w_rd,
        input logic [DATA_W-1:0] w_data
    );
        if (m_en && (m_rd == idx) && (idx != '0))
            return m_data;
        else if (w_en && (w_rd == idx) && (idx != '0))
            return w_data;
        else
            return stored;
    endfunction

    always_comb begin
        w_fwd_rs = fwd_sel(r_rs, r_rs_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        w_fwd_rt = fwd_sel(r_rt, r_rt_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    end

    assign ex_valid      = r_valid;
    assign aluOp         = r_alu_op;
    assign ex_illegal    = r_illegal;
    assign ex_dest       = r_dest;
    assign data1         = w_fwd_rs;
    assign ex_store_data = w_fwd_rt;
    assign data2         = r_alu_src ? r_imm : w_fwd_rt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage against an instruction-level model
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid, id_alu_src;
    logic [1:0]  id_op_class;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_illegal;
    logic [3:0]  aluOp;
    logic [31:0] data1, data2, ex_store_data;
    logic [4:0]  ex_dest;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_op_class(id_op_class), .id_funct(id_funct),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .aluOp(aluOp), .data1(data1), .data2(data2),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic        ill;
        logic [4:0]  dest;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sd;
    } exp_t;

    // Instruction currently held in EX, as the model sees it.
    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic        ill;
        logic        src;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
    } instr_t;

    exp_t   sb_q[$];
    instr_t m;
    logic [3:0] rtype_op [logic [5:0]];
    int checks = 0;
    int errors = 0;
    bit done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 0) return stored;
        if (mem_fwd_en && mem_fwd_rd == idx) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_rd == idx) return wb_fwd_data;
        return stored;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs, then queue the expectation.
    task automatic cycle();
        exp_t e;
        if (reset || flush) begin
            m = '{v: 0, op: 0, ill: 0, src: 0, rs: 0, rt: 0, dest: 0, rsd: 0, rtd: 0, imm: 0};
        end else if (!stall) begin
            m.v = id_valid;
            m.ill = 1'b0;
            if (id_op_class == 2'd0)      m.op = 4'd2;
            else if (id_op_class == 2'd1) m.op = 4'd6;
            else if (id_op_class == 2'd2 && rtype_op.exists(id_funct)) m.op = rtype_op[id_funct];
            else begin
                m.op = 4'd0;
                m.ill = id_valid;
            end
            m.src = id_alu_src;
            m.rs = id_rs; m.rt = id_rt; m.dest = id_dest;
            m.rsd = id_rs_data; m.rtd = id_rt_data;
            m.imm = 32'($signed(id_imm));
        end
        e.v = m.v; e.op = m.op; e.ill = m.ill; e.dest = m.dest;
        e.d1 = fwd(m.rs, m.rsd);
        e.sd = fwd(m.rt, m.rtd);
        e.d2 = m.src ? m.imm : e.sd;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; flush = 0; id_valid = 0; id_alu_src = 0;
        id_op_class = 0; id_funct = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_dest = 0;
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    task automatic load(input logic [1:0] cls, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic src, input logic [15:0] imm);
        id_valid = 1; id_op_class = cls; id_funct = fn; id_rs = rs; id_rt = rt;
        id_rs_data = rsd; id_rt_data = rtd; id_alu_src = src; id_imm = imm;
        id_dest = 5'($urandom_range(0, 31));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(e.v));
                chk("aluOp", 32'(aluOp), 32'(e.op));
                chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
                chk("ex_dest", 32'(ex_dest), 32'(e.dest));
                chk("data1", data1, e.d1);
                chk("data2", data2, e.d2);
                chk("ex_store_data", ex_store_data, e.sd);
            end
        end
    end

    initial begin : driver
        rtype_op[6'b100100] = 4'b0000;
        rtype_op[6'b100101] = 4'b0001;
        rtype_op[6'b100000] = 4'b0010;
        rtype_op[6'b100010] = 4'b0110;
        rtype_op[6'b101010] = 4'b0111;
        rtype_op[6'b100111] = 4'b1100;
        m = '{v: 1, op: 4'hf, ill: 1, src: 1, rs: 1, rt: 1, dest: 1, rsd: 1, rtd: 1, imm: 1};

        clear_inputs();
        reset = 1;
        cycle(); cycle();
        reset = 0;
        cycle();

        load(2'b10, 6'b100010, 5'd1, 5'd2, 32'h5, 32'h3, 0, 16'h0);
        cycle();
        load(2'b00, 6'b0, 5'd3, 5'd4, 32'h100, 32'h9, 1, 16'hFFFC);
        cycle();

        load(2'b10, 6'b100000, 5'd7, 5'd7, 32'h1111, 32'h2222, 0, 16'h0);
        mem_fwd_en = 1; mem_fwd_rd = 7; mem_fwd_data = 32'hAAAA0000;
        wb_fwd_en = 1;  wb_fwd_rd = 7;  wb_fwd_data = 32'h5555;
        cycle();
        load(2'b10, 6'b100000, 5'd0, 5'd0, 32'h1234, 32'h5678, 0, 16'h0);
        mem_fwd_rd = 0; wb_fwd_rd = 0;
        cycle();
        mem_fwd_en = 0; wb_fwd_en = 0;

        load(2'b10, 6'b101010, 5'd9, 5'd10, 32'hCAFE, 32'hBEEF, 0, 16'h0);
        cycle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            load(2'($urandom_range(0, 3)), 6'($urandom), 5'($urandom), 5'($urandom),
                 $urandom, $urandom, 1'($urandom), 16'($urandom));
            cycle();
        end
        flush = 1;
        cycle();
        stall = 0; flush = 0;

        load(2'b10, 6'b000000, 5'd2, 5'd3, 32'h1, 32'h2, 0, 16'h0);
        cycle();
        load(2'b11, 6'b100000, 5'd2, 5'd3, 32'h1, 32'h2, 0, 16'h0);
        id_valid = 0;
        cycle();

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 20);
            load(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7) ? 6'(6'b100000 | 6'($urandom_range(0, 10))) : 6'($urandom),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom, 1'($urandom), 16'($urandom));
            id_valid = ($urandom_range(0, 9) < 8);
            mem_fwd_en = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
            wb_fwd_en = 1'($urandom);  wb_fwd_rd = 5'($urandom_range(0, 7));  wb_fwd_data = $urandom;
            cycle();
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
